// File: rtl/conv_window_scheduler_pkg.sv
// rtl/conv_window_scheduler_pkg.sv - shared types and helpers for the conv window scheduler
package conv_window_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } sched_state_t;

    localparam int RELU_MAX_W = 64;

    function automatic int calc_outsz(input int size, input int sizeker, input int stride);
        return (size - sizeker) / stride + 1;
    endfunction

    function automatic int calc_idx_w(input int size);
        return ($clog2(size) > 0) ? $clog2(size) : 1;
    endfunction

    // Operates on a wide container so one function serves every pixel width.
    function automatic logic [RELU_MAX_W-1:0] relu(input logic [RELU_MAX_W-1:0] data, input int width);
        return data[width-1] ? '0 : data;
    endfunction

endpackage

// File: rtl/conv_window_scheduler_index.sv
// rtl/conv_window_scheduler_index.sv - raster walker over output positions with window origin
module window_index_counter #(
    parameter int OUTSZ  = 5,
    parameter int STRIDE = 1,
    parameter int IDX_W  = 3
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic [IDX_W-1:0] out_row_o,
    output logic [IDX_W-1:0] out_col_o,
    output logic [IDX_W-1:0] win_row_o,
    output logic [IDX_W-1:0] win_col_o,
    output logic             last_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTSZ - 1);
    localparam logic [IDX_W-1:0] STRIDE_W = IDX_W'(STRIDE);

    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (advance_i) begin
            if (col_q == LAST_IDX) begin
                col_d = '0;
                row_d = (row_q == LAST_IDX) ? '0 : row_q + IDX_W'(1);
            end else begin
                col_d = col_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign out_row_o = row_q;
    assign out_col_o = col_q;
    assign win_row_o = row_q * STRIDE_W;
    assign win_col_o = col_q * STRIDE_W;
    assign last_o    = (row_q == LAST_IDX) && (col_q == LAST_IDX);

endmodule

// File: rtl/conv_window_scheduler.sv
// rtl/conv_window_scheduler.sv - drives one shared KxK conv engine across every output position
module conv_window_scheduler
    import conv_window_scheduler_pkg::*;
#(
    parameter  int SIZE      = 7,
    parameter  int SIZEKER   = 3,
    parameter  int WIDTH_BIT = 8,
    parameter  int STRIDE    = 1,
    parameter  int WAIT_MAX  = 15,
    localparam int OUTSZ     = calc_outsz(SIZE, SIZEKER, STRIDE),
    localparam int IDX_W     = calc_idx_w(SIZE)
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic                        win_valid_o,
    input  logic                        win_ready_i,
    output logic [IDX_W-1:0]            win_row_o,
    output logic [IDX_W-1:0]            win_col_o,
    input  logic                        res_valid_i,
    input  logic signed [WIDTH_BIT-1:0] res_data_i,
    output logic                        out_we_o,
    output logic [IDX_W-1:0]            out_row_o,
    output logic [IDX_W-1:0]            out_col_o,
    output logic signed [WIDTH_BIT-1:0] out_data_o
);

    localparam int               WAIT_W    = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    sched_state_t         state_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;
    logic                 win_valid_q;
    logic                 out_we_q;
    logic [WAIT_W-1:0]    wait_cnt_q;
    logic [WIDTH_BIT-1:0] res_q;

    logic                 idx_clear;
    logic                 idx_advance;
    logic                 idx_last;
    logic [WIDTH_BIT-1:0] relu_res;

    assign idx_clear   = (state_q == IDLE) && start_i;
    assign idx_advance = (state_q == WRITE);
    assign relu_res    = WIDTH_BIT'(relu(RELU_MAX_W'($unsigned(res_data_i)), WIDTH_BIT));

    window_index_counter #(
        .OUTSZ (OUTSZ),
        .STRIDE(STRIDE),
        .IDX_W (IDX_W)
    ) u_index (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .clear_i  (idx_clear),
        .advance_i(idx_advance),
        .out_row_o(out_row_o),
        .out_col_o(out_col_o),
        .win_row_o(win_row_o),
        .win_col_o(win_col_o),
        .last_o   (idx_last)
    );

    // A result arriving on the timeout cycle is checked first so it wins.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            win_valid_q <= 1'b0;
            out_we_q    <= 1'b0;
            wait_cnt_q  <= '0;
            res_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q     <= ISSUE;
                        busy_q      <= 1'b1;
                        win_valid_q <= 1'b1;
                        error_q     <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (win_ready_i) begin
                        state_q     <= WAIT;
                        win_valid_q <= 1'b0;
                        wait_cnt_q  <= '0;
                    end
                end
                WAIT: begin
                    if (res_valid_i) begin
                        res_q    <= relu_res;
                        out_we_q <= 1'b1;
                        state_q  <= WRITE;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        res_q    <= '0;
                        error_q  <= 1'b1;
                        out_we_q <= 1'b1;
                        state_q  <= WRITE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                WRITE: begin
                    out_we_q <= 1'b0;
                    if (idx_last) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q     <= ISSUE;
                        win_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign win_valid_o = win_valid_q;
    assign out_we_o    = out_we_q;
    assign out_data_o  = res_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb/tb_conv_window_scheduler.sv - directed bench for conv_window_scheduler
module tb_conv_window_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_s     [2];
    logic       win_ready_s [2];
    logic       res_valid_s [2];
    logic [7:0] res_data_s  [2];
    logic       busy_s      [2];
    logic       done_s      [2];
    logic       error_s     [2];
    logic       win_valid_s [2];
    logic       out_we_s    [2];
    logic [2:0] win_row_s   [2];
    logic [2:0] win_col_s   [2];
    logic [2:0] out_row_s   [2];
    logic [2:0] out_col_s   [2];
    logic [7:0] out_data_s  [2];

    conv_window_scheduler dut (
        .clock_i(clk), .reset_i(rst), .start_i(start_s[0]),
        .busy_o(busy_s[0]), .done_o(done_s[0]), .error_o(error_s[0]),
        .win_valid_o(win_valid_s[0]), .win_ready_i(win_ready_s[0]),
        .win_row_o(win_row_s[0]), .win_col_o(win_col_s[0]),
        .res_valid_i(res_valid_s[0]), .res_data_i(res_data_s[0]),
        .out_we_o(out_we_s[0]), .out_row_o(out_row_s[0]), .out_col_o(out_col_s[0]),
        .out_data_o(out_data_s[0])
    );

    conv_window_scheduler #(.STRIDE(2)) dut_s2 (
        .clock_i(clk), .reset_i(rst), .start_i(start_s[1]),
        .busy_o(busy_s[1]), .done_o(done_s[1]), .error_o(error_s[1]),
        .win_valid_o(win_valid_s[1]), .win_ready_i(win_ready_s[1]),
        .win_row_o(win_row_s[1]), .win_col_o(win_col_s[1]),
        .res_valid_i(res_valid_s[1]), .res_data_i(res_data_s[1]),
        .out_we_o(out_we_s[1]), .out_row_o(out_row_s[1]), .out_col_o(out_col_s[1]),
        .out_data_o(out_data_s[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Engine result stimulus and the hand-computed ReLU of each value.
    int alt_res [2] = '{5, -3};
    int alt_exp [2] = '{5, 0};
    int bnd_res [7] = '{127, -128, 0, -1, 1, 64, -64};
    int bnd_exp [7] = '{127, 0, 0, 0, 1, 64, 0};

    function automatic int resv(input int pat, input int k);
        return (pat == 0) ? alt_res[k % 2] : bnd_res[k % 7];
    endfunction

    function automatic int expv(input int pat, input int k);
        return (pat == 0) ? alt_exp[k % 2] : bnd_exp[k % 7];
    endfunction

    typedef struct {
        int inst;
        int stall_k;
        int drop_k;
        int abort_k;
        bit poke;
        int pat;
        int exp_writes;
        bit exp_error;
    } layer_t;

    task automatic run_layer(input layer_t l);
        int  i;
        int  outsz;
        int  st;
        int  k_iss;
        int  k_wr;
        int  pend;
        int  rv_k;
        int  stall_cnt;
        int  done_cnt;
        int  after_done;
        int  abort_at;
        int  hs_cyc [32];
        bit  fin;
        bit  rdy;
        i = l.inst;
        outsz = (i == 1) ? 3 : 5;
        st = (i == 1) ? 2 : 1;
        k_iss = 0; k_wr = 0; pend = 0; rv_k = 0; stall_cnt = 0;
        done_cnt = 0; after_done = -1; abort_at = -1; fin = 1'b0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            if (out_we_s[i]) begin
                check("write_row", out_row_s[i], k_wr / outsz);
                check("write_col", out_col_s[i], k_wr % outsz);
                check("write_data", out_data_s[i], (k_wr == l.drop_k) ? 0 : expv(l.pat, k_wr));
                check("write_error", error_s[i], (l.drop_k >= 0 && k_wr >= l.drop_k) ? 1 : 0);
                if (k_wr < 32)
                    check("write_latency", cyc - hs_cyc[k_wr], (k_wr == l.drop_k) ? 16 : 3);
                k_wr++;
            end
            if (done_s[i]) begin
                check("done_writes", k_wr, outsz * outsz);
                check("done_busy", busy_s[i], 1);
                done_cnt++;
                after_done = cyc;
            end
            if (after_done >= 0 && cyc == after_done + 1) begin
                check("post_done_busy", busy_s[i], 0);
                check("post_done_done", done_s[i], 0);
                fin = 1'b1;
            end
            if (abort_at >= 0 && cyc == abort_at + 1) begin
                rst = 1'b0;
                check("abort_busy", busy_s[i], 0);
                check("abort_done", done_s[i], 0);
                check("abort_we", out_we_s[i], 0);
                check("abort_win_valid", win_valid_s[i], 0);
                fin = 1'b1;
            end else if (abort_at >= 0 && cyc == abort_at) begin
                rst = 1'b1;
            end
            start_s[i] = (cyc == 0) || (l.poke && cyc == 20);
            res_valid_s[i] = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    res_valid_s[i] = 1'b1;
                    res_data_s[i]  = 8'(resv(l.pat, rv_k));
                end
            end
            rdy = 1'b1;
            if (win_valid_s[i]) begin
                check("win_row", win_row_s[i], (k_iss / outsz) * st);
                check("win_col", win_col_s[i], (k_iss % outsz) * st);
                if (k_iss == l.stall_k && stall_cnt < 10) begin
                    rdy = 1'b0;
                    stall_cnt++;
                end
            end
            win_ready_s[i] = rdy;
            if (win_valid_s[i] && rdy && abort_at < 0) begin
                if (k_iss < 32) hs_cyc[k_iss] = cyc;
                rv_k = k_iss;
                pend = (k_iss == l.drop_k) ? 0 : 2;
                if (k_iss == l.abort_k) abort_at = cyc + 1;
                k_iss++;
            end
        end
        if (!fin) check("layer_timeout", 0, 1);
        start_s[i] = 1'b0;
        res_valid_s[i] = 1'b0;
        win_ready_s[i] = 1'b1;
        rst = 1'b0;
        check("layer_writes", k_wr, l.exp_writes);
        check("layer_done_pulses", done_cnt, (l.abort_k >= 0) ? 0 : 1);
        check("layer_error", error_s[i], l.exp_error);
    endtask

    layer_t layers [8];

    initial begin
        //            inst stall drop abort poke pat writes err
        layers[0] = '{0, -1, -1, -1, 1'b0, 0, 25, 1'b0};
        layers[1] = '{0,  2, -1, -1, 1'b0, 0, 25, 1'b0};
        layers[2] = '{0, -1,  6, -1, 1'b0, 0, 25, 1'b1};
        layers[3] = '{1, -1, -1, -1, 1'b0, 0,  9, 1'b0};
        layers[4] = '{0, -1, -1, 13, 1'b0, 0, 13, 1'b0};
        layers[5] = '{0, -1, -1, -1, 1'b1, 1, 25, 1'b0};
        layers[6] = '{1, -1,  8, -1, 1'b0, 1,  9, 1'b1};
        layers[7] = '{0, 24, 24, -1, 1'b0, 0, 25, 1'b1};

        rst = 1'b1;
        for (int j = 0; j < 2; j++) begin
            start_s[j] = 1'b0;
            win_ready_s[j] = 1'b1;
            res_valid_s[j] = 1'b0;
            res_data_s[j] = 8'd0;
        end
        repeat (3) @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            check("reset_busy", busy_s[j], 0);
            check("reset_done", done_s[j], 0);
            check("reset_error", error_s[j], 0);
            check("reset_win_valid", win_valid_s[j], 0);
            check("reset_out_we", out_we_s[j], 0);
            check("reset_win_pos", {win_row_s[j], win_col_s[j]}, 0);
            check("reset_out_pos", {out_row_s[j], out_col_s[j]}, 0);
            check("reset_out_data", out_data_s[j], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 8; n++) begin
            run_layer(layers[n]);
            repeat (2) @(negedge clk);
        end

        for (int c = 0; c < 6; c++) begin
            res_valid_s[0] = 1'b1;
            res_data_s[0]  = 8'd9;
            @(negedge clk);
            check("idle_res_we", out_we_s[0], 0);
            check("idle_res_busy", busy_s[0], 0);
        end
        res_valid_s[0] = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
